// File: rtl/snake_pkg.sv
// Shared encodings for the snake engine: travel directions, icon codes and FSM states.
package snake_pkg;

  typedef enum logic [1:0] {
    NORTH = 2'd0,
    SOUTH = 2'd1,
    WEST  = 2'd2,
    EAST  = 2'd3
  } dir_t;

  localparam logic [1:0] ICON_NONE = 2'b00;
  localparam logic [1:0] ICON_BODY = 2'b01;
  localparam logic [1:0] ICON_HEAD = 2'b10;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RUN   = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] OVER  = 3'd4;

  function automatic dir_t opposite(input dir_t d);
    dir_t r;
    case (d)
      NORTH:   r = SOUTH;
      SOUTH:   r = NORTH;
      WEST:    r = EAST;
      EAST:    r = WEST;
      default: r = WEST;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snake_ring_buffer.sv
// Ordered list of body cells, tail first; the head pointer marks the newest cell.
module snake_ring_buffer #(
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3,
  parameter int XW       = 5,
  parameter int YW       = 5,
  parameter int START_X  = 16,
  parameter int START_Y  = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [XW-1:0] push_x,
  input  logic [YW-1:0] push_y,
  output logic [XW-1:0] tail_x,
  output logic [YW-1:0] tail_y
);

  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_LEN - 1);

  logic [XW+YW-1:0] mem_r [MAX_LEN];
  logic [PW-1:0]    head_ptr_r;
  logic [PW-1:0]    tail_ptr_r;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == PTR_LAST) r = '0;
    else r = p + PW'(1);
    return r;
  endfunction

  // Storage and pointers; reset preloads the initial body running west to east
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) mem_r[i] <= {YW'(START_Y), XW'(START_X - (INIT_LEN - 1) + i)};
        else mem_r[i] <= '0;
      end
      head_ptr_r <= PW'(INIT_LEN - 1);
      tail_ptr_r <= '0;
    end else begin
      if (push) begin
        mem_r[ptr_inc(head_ptr_r)] <= {push_y, push_x};
        head_ptr_r                 <= ptr_inc(head_ptr_r);
      end
      if (pop) tail_ptr_r <= ptr_inc(tail_ptr_r);
    end
  end

  assign {tail_y, tail_x} = mem_r[tail_ptr_r];

endmodule

// File: rtl/snake_engine.sv
// Snake head motion, occupancy bitmap, collision/growth sequencing and pixel-to-icon lookup.
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_W      = 32,
  parameter int GRID_H      = 24,
  parameter int CELL_SHIFT  = 4,
  parameter int MAX_LEN     = 64,
  parameter int INIT_LEN    = 3,
  parameter int STEP_CYCLES = 4000000,
  parameter int WRAP        = 0,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          iWest,
  input  logic          iEast,
  input  logic          iNorth,
  input  logic          iSouth,
  input  logic [XW-1:0] iFoodX,
  input  logic [YW-1:0] iFoodY,
  input  logic [10:0]   iPixelCol,
  input  logic [10:0]   iPixelRow,
  output logic [1:0]    oIcon,
  output logic [XW-1:0] oHeadX,
  output logic [YW-1:0] oHeadY,
  output logic [LW-1:0] oLength,
  output logic          oFoodEaten,
  output logic          oStepTick,
  output logic          oGameOver
);

  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(GRID_H - 1);
  localparam logic [XW-1:0] X_START   = XW'(GRID_W / 2);
  localparam logic [YW-1:0] Y_START   = YW'(GRID_H / 2);
  localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);
  localparam logic [LW-1:0] LEN_INIT  = LW'(INIT_LEN);
  localparam logic [10:0]   COLS      = 11'(GRID_W);
  localparam logic [10:0]   ROWS      = 11'(GRID_H);

  // Bitmap is addressed by {y, x}; cells beyond the grid are never written.
  logic [(1 << (XW + YW))-1:0] bitmap_r;
  logic [2:0]    state_r;
  logic [TW-1:0] tick_r;
  dir_t          dir_r, pend_r, step_dir_r, req_dir_s, ref_dir_s;
  logic          req_valid_s, accept_s;
  logic [XW-1:0] nx_s, next_x_r, tail_x_s, pix_x_s;
  logic [YW-1:0] ny_s, next_y_r, tail_y_s, pix_y_s;
  logic          at_edge_s, wall_s, eat_s, grow_s, tail_hit_s, collide_s;
  logic          grow_r, eat_r, in_grid_s;
  logic [10:0]   pix_cx_s, pix_cy_s;
  logic [1:0]    icon_s;

  snake_ring_buffer #(
    .MAX_LEN (MAX_LEN),
    .INIT_LEN(INIT_LEN),
    .XW      (XW),
    .YW      (YW),
    .START_X (GRID_W / 2),
    .START_Y (GRID_H / 2)
  ) u_ring (
    .clk   (Clock),
    .rst_n (Reset),
    .push  (state_r == WRITE),
    .pop   ((state_r == WRITE) && !grow_r),
    .push_x(next_x_r),
    .push_y(next_y_r),
    .tail_x(tail_x_s),
    .tail_y(tail_y_s)
  );

  // Button priority N > S > W > E
  always_comb begin
    req_valid_s = 1'b1;
    req_dir_s   = EAST;
    if (iNorth) req_dir_s = NORTH;
    else if (iSouth) req_dir_s = SOUTH;
    else if (iWest) req_dir_s = WEST;
    else if (iEast) req_dir_s = EAST;
    else req_valid_s = 1'b0;
  end

  // Reversal is judged against the direction the current step will commit
  always_comb begin
    ref_dir_s = dir_r;
    case (state_r)
      CHECK:   ref_dir_s = pend_r;
      WRITE:   ref_dir_s = step_dir_r;
      default: ref_dir_s = dir_r;
    endcase
  end

  assign accept_s = req_valid_s && (req_dir_s != opposite(ref_dir_s));

  // Candidate next head, always wrapped; the wall term decides whether wrapping is legal
  always_comb begin
    nx_s      = oHeadX;
    ny_s      = oHeadY;
    at_edge_s = 1'b0;
    case (pend_r)
      NORTH: begin at_edge_s = (oHeadY == '0);     ny_s = at_edge_s ? Y_LAST : oHeadY - YW'(1); end
      SOUTH: begin at_edge_s = (oHeadY == Y_LAST); ny_s = at_edge_s ? '0 : oHeadY + YW'(1);     end
      WEST:  begin at_edge_s = (oHeadX == '0);     nx_s = at_edge_s ? X_LAST : oHeadX - XW'(1); end
      EAST:  begin at_edge_s = (oHeadX == X_LAST); nx_s = at_edge_s ? '0 : oHeadX + XW'(1);     end
      default: at_edge_s = 1'b0;
    endcase
  end

  assign wall_s     = (WRAP == 0) && at_edge_s;
  assign eat_s      = (nx_s == iFoodX) && (ny_s == iFoodY);
  assign grow_s     = eat_s && (oLength < LEN_MAX);
  assign tail_hit_s = (nx_s == tail_x_s) && (ny_s == tail_y_s);
  assign collide_s  = wall_s || (bitmap_r[{ny_s, nx_s}] && !(tail_hit_s && !grow_s));

  // Step sequencer with committed head, length, occupancy map and status pulses
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_r    <= IDLE;
      dir_r      <= EAST;
      pend_r     <= EAST;
      step_dir_r <= EAST;
      tick_r     <= '0;
      oHeadX     <= X_START;
      oHeadY     <= Y_START;
      oLength    <= LEN_INIT;
      next_x_r   <= '0;
      next_y_r   <= '0;
      grow_r     <= 1'b0;
      eat_r      <= 1'b0;
      oFoodEaten <= 1'b0;
      oStepTick  <= 1'b0;
      oGameOver  <= 1'b0;
      bitmap_r   <= '0;
      for (int i = 0; i < INIT_LEN; i++) bitmap_r[{Y_START, XW'(GRID_W / 2 - i)}] <= 1'b1;
    end else begin
      oFoodEaten <= 1'b0;
      oStepTick  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid_s) begin
            state_r <= RUN;
            if (accept_s) pend_r <= req_dir_s;
          end
        end
        RUN: begin
          if (accept_s) pend_r <= req_dir_s;
          if (tick_r == TICK_LAST) begin
            tick_r  <= '0;
            state_r <= CHECK;
          end else begin
            tick_r <= tick_r + TW'(1);
          end
        end
        CHECK: begin
          if (accept_s) pend_r <= req_dir_s;
          next_x_r   <= nx_s;
          next_y_r   <= ny_s;
          step_dir_r <= pend_r;
          grow_r     <= grow_s;
          eat_r      <= eat_s;
          if (collide_s) begin
            state_r   <= OVER;
            oGameOver <= 1'b1;
          end else begin
            state_r <= WRITE;
          end
        end
        WRITE: begin
          if (accept_s) pend_r <= req_dir_s;
          // Clear before set so a head entering the vacating tail cell leaves the bit at 1
          if (!grow_r) bitmap_r[{tail_y_s, tail_x_s}] <= 1'b0;
          bitmap_r[{next_y_r, next_x_r}] <= 1'b1;
          oHeadX     <= next_x_r;
          oHeadY     <= next_y_r;
          dir_r      <= step_dir_r;
          if (grow_r) oLength <= oLength + LW'(1);
          oStepTick  <= 1'b1;
          oFoodEaten <= eat_r;
          state_r    <= RUN;
        end
        OVER:    oGameOver <= 1'b1;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign pix_cx_s  = iPixelCol >> CELL_SHIFT;
  assign pix_cy_s  = iPixelRow >> CELL_SHIFT;
  assign in_grid_s = (pix_cx_s < COLS) && (pix_cy_s < ROWS);
  assign pix_x_s   = pix_cx_s[XW-1:0];
  assign pix_y_s   = pix_cy_s[YW-1:0];

  // Icon for the pixel currently being scanned
  always_comb begin
    icon_s = ICON_NONE;
    if (!in_grid_s) icon_s = ICON_NONE;
    else if ((pix_x_s == oHeadX) && (pix_y_s == oHeadY)) icon_s = ICON_HEAD;
    else if (bitmap_r[{pix_y_s, pix_x_s}]) icon_s = ICON_BODY;
    else icon_s = ICON_NONE;
  end

  // Registered icon output
  always_ff @(posedge Clock) begin
    if (!Reset) oIcon <= ICON_NONE;
    else oIcon <= icon_s;
  end

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench: a wrapping and a walled engine driven with identical stimulus.
module tb_snake_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        b_w = 1'b0, b_e = 1'b0, b_n = 1'b0, b_s = 1'b0;
  logic [4:0]  food_x = 5'd0;
  logic [4:0]  food_y = 5'd0;
  logic [10:0] pcol = 11'd0, prow = 11'd0;

  logic [1:0] wrap_icon, wall_icon;
  logic [4:0] wrap_hx, wall_hx, wrap_hy, wall_hy;
  logic [6:0] wrap_len, wall_len;
  logic       wrap_eat, wall_eat, wrap_tick, wall_tick, wrap_over, wall_over;

  int tests = 0;
  int fails = 0;

  int seg_d [6] = '{3, 1, 3, 0, 3, 1};
  int seg_n [6] = '{1, 23, 1, 23, 1, 13};
  int loop_d [7] = '{0, 2, 1, 3, 0, 2, 1};
  int loop_x [7] = '{17, 16, 16, 17, 17, 16, 16};
  int loop_y [7] = '{11, 11, 12, 12, 11, 11, 12};

  always #5 clk = ~clk;

  snake_engine #(.STEP_CYCLES(4), .WRAP(1)) u_wrap (
    .Clock(clk), .Reset(rst_n), .iWest(b_w), .iEast(b_e), .iNorth(b_n), .iSouth(b_s),
    .iFoodX(food_x), .iFoodY(food_y), .iPixelCol(pcol), .iPixelRow(prow),
    .oIcon(wrap_icon), .oHeadX(wrap_hx), .oHeadY(wrap_hy), .oLength(wrap_len),
    .oFoodEaten(wrap_eat), .oStepTick(wrap_tick), .oGameOver(wrap_over)
  );

  snake_engine #(.STEP_CYCLES(4), .WRAP(0)) u_wall (
    .Clock(clk), .Reset(rst_n), .iWest(b_w), .iEast(b_e), .iNorth(b_n), .iSouth(b_s),
    .iFoodX(food_x), .iFoodY(food_y), .iPixelCol(pcol), .iPixelRow(prow),
    .oIcon(wall_icon), .oHeadX(wall_hx), .oHeadY(wall_hy), .oLength(wall_len),
    .oFoodEaten(wall_eat), .oStepTick(wall_tick), .oGameOver(wall_over)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input int d);
    b_n = (d == 0);
    b_s = (d == 1);
    b_w = (d == 2);
    b_e = (d == 3);
  endtask

  task automatic do_reset();
    set_btn(-1);
    food_x = 5'd0;
    food_y = 5'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_step(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wrap_tick && n < 30);
    check(tag, {31'd0, wrap_tick}, 32'd1);
  endtask

  task automatic pix(input string tag, input int col, input int row, input int exp);
    pcol = 11'(col);
    prow = 11'(row);
    @(negedge clk);
    check(tag, {30'd0, wrap_icon}, 32'(exp));
  endtask

  initial begin
    int x, y, k, ticks;

    // Reset state and idle
    do_reset();
    @(negedge clk);
    check("rst_hx", wrap_hx, 32'd16);
    check("rst_hy", wrap_hy, 32'd12);
    check("rst_len", wrap_len, 32'd3);
    check("rst_over", wrap_over, 32'd0);
    check("rst_eat", wrap_eat, 32'd0);
    check("rst_wall_len", wall_len, 32'd3);
    ticks = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ticks += int'(wrap_tick) + int'(wall_tick);
    end
    check("idle_ticks", ticks, 32'd0);
    pix("pix_b15", 240, 192, 1);
    pix("pix_b14", 224, 192, 1);
    pix("pix_e13", 208, 192, 0);
    pix("pix_off", 600, 100, 0);
    pcol = 11'd256;
    prow = 11'd192;
    #1 check("pix_lat0", wrap_icon, 32'd0);
    @(negedge clk);
    check("pix_lat1", wrap_icon, 32'd2);

    // North with vertical wrap; the walled engine dies at row 0
    b_n = 1'b1;
    @(negedge clk);
    b_n = 1'b0;
    for (k = 1; k <= 13; k++) begin
      wait_step("n_tick");
      check("n_wrap_y", wrap_hy, (k <= 12) ? 32'(12 - k) : 32'd23);
      check("n_wrap_x", wrap_hx, 32'd16);
      if (k <= 12) check("n_wall_y", wall_hy, 32'(12 - k));
    end
    repeat (8) @(negedge clk);
    check("n_wall_over", wall_over, 32'd1);
    check("n_wall_frozen", wall_hy, 32'd0);
    check("n_wrap_over", wrap_over, 32'd0);

    // East wall hit; west press from idle is a reversal and keeps east
    do_reset();
    b_w = 1'b1;
    @(negedge clk);
    b_w = 1'b0;
    for (k = 1; k <= 15; k++) begin
      wait_step("e_tick");
      check("e_wall_x", wall_hx, 32'(16 + k));
      check("e_wall_over0", wall_over, 32'd0);
    end
    repeat (10) @(negedge clk);
    check("e_wall_over", wall_over, 32'd1);
    check("e_wall_hx", wall_hx, 32'd31);
    check("e_wall_hy", wall_hy, 32'd12);
    check("e_wrap_x", wrap_hx, 32'd0);
    check("e_wrap_over", wrap_over, 32'd0);

    // Growth to capacity along a collision-free serpentine
    do_reset();
    x = 16;
    y = 12;
    k = 0;
    for (int s = 0; s < 6; s++) begin
      for (int j = 0; j < seg_n[s]; j++) begin
        case (seg_d[s])
          0: y = (y + 23) % 24;
          1: y = (y + 1) % 24;
          2: x = (x + 31) % 32;
          default: x = (x + 1) % 32;
        endcase
        food_x = 5'(x);
        food_y = 5'(y);
        set_btn(seg_d[s]);
        wait_step("g_tick");
        k++;
        check("g_hx", wrap_hx, 32'(x));
        check("g_hy", wrap_hy, 32'(y));
        check("g_len", wrap_len, (3 + k > 64) ? 32'd64 : 32'(3 + k));
        check("g_eat", wrap_eat, 32'd1);
      end
    end
    check("g_over", wrap_over, 32'd0);

    // Self collision of a length-5 snake turning N, W, S
    do_reset();
    food_x = 5'd17;
    food_y = 5'd12;
    set_btn(3);
    wait_step("c_tick");
    check("c_len4", wrap_len, 32'd4);
    food_x = 5'd18;
    wait_step("c_tick");
    check("c_len5", wrap_len, 32'd5);
    food_x = 5'd0;
    food_y = 5'd0;
    set_btn(0);
    wait_step("c_tick");
    set_btn(2);
    wait_step("c_tick");
    check("c_hx", wrap_hx, 32'd17);
    set_btn(1);
    repeat (10) @(negedge clk);
    check("c_over", wrap_over, 32'd1);
    check("c_frozen_x", wrap_hx, 32'd17);
    check("c_frozen_y", wrap_hy, 32'd11);
    check("c_len", wrap_len, 32'd5);

    // Length-4 square loop chasing its own vacating tail
    do_reset();
    food_x = 5'd17;
    food_y = 5'd12;
    set_btn(3);
    wait_step("t_tick");
    check("t_len4", wrap_len, 32'd4);
    food_x = 5'd0;
    food_y = 5'd0;
    for (int j = 0; j < 7; j++) begin
      set_btn(loop_d[j]);
      wait_step("t_tick");
      check("t_hx", wrap_hx, 32'(loop_x[j]));
      check("t_hy", wrap_hy, 32'(loop_y[j]));
      check("t_over", wrap_over, 32'd0);
      check("t_len", wrap_len, 32'd4);
    end
    pix("t_pix_head", 256, 192, 2);
    pix("t_pix_b1712", 272, 192, 1);
    pix("t_pix_b1611", 256, 176, 1);
    pix("t_pix_b1711", 272, 176, 1);
    pix("t_pix_gone", 240, 192, 0);

    // Reversal rejection and N-over-S priority
    do_reset();
    set_btn(3);
    wait_step("r_tick");
    check("r_hx1", wrap_hx, 32'd17);
    b_w = 1'b1;
    @(negedge clk);
    set_btn(-1);
    wait_step("r_tick");
    check("r_rev_x", wrap_hx, 32'd18);
    check("r_rev_y", wrap_hy, 32'd12);
    b_n = 1'b1;
    b_s = 1'b1;
    wait_step("r_tick");
    check("r_pri_x", wrap_hx, 32'd18);
    check("r_pri_y", wrap_hy, 32'd11);
    set_btn(-1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
